// File: rtl/ahb2_pkg.sv
// Shared AMBA2 AHB encodings used by the team's AHB2 initiators, interconnect and responders.
package ahb2_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HSIZE_8BITS    = 3'b000;
   localparam logic [2:0] HSIZE_16BITS   = 3'b001;
   localparam logic [2:0] HSIZE_32BITS   = 3'b010;
   localparam logic [2:0] HSIZE_64BITS   = 3'b011;
   localparam logic [2:0] HSIZE_128BITS  = 3'b100;
   localparam logic [2:0] HSIZE_256BITS  = 3'b101;
   localparam logic [2:0] HSIZE_512BITS  = 3'b110;
   localparam logic [2:0] HSIZE_1024BITS = 3'b111;

endpackage

// File: rtl/ahb2_sram_mem.sv
// DEPTH x 32-bit flop array with per-byte write enables and an asynchronous read port.
// Read and write share one index because a data phase only ever touches one word.
module ahb2_sram_mem #(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             hclk,
   input  logic             hreset_n,
   input  logic [3:0]       we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Clearing on reset means a transfer aborted by reset can never leave stale data behind.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
               mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb2_sram_slave.sv
// AHB2 responder terminating transfers into a byte-writable SRAM model, with
// programmable wait states and the two-cycle ERROR response (no RETRY/SPLIT).
module ahb2_sram_slave
   import ahb2_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              hsel_i,
   input  logic [ADDR_W-1:0] haddr_i,
   input  logic [1:0]        htrans_i,
   input  logic              hwrite_i,
   input  logic [2:0]        hsize_i,
   input  logic [2:0]        hburst_i,
   input  logic [31:0]       hwdata_i,
   input  logic              hready_i,
   output logic [31:0]       hrdata_o,
   output logic              hreadyout_o,
   output logic [1:0]        hresp_o
);

   localparam int         IDX_W       = $clog2(DEPTH);
   localparam logic [3:0] WAIT_RELOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR1,
      S_ERR2
   } state_e;

   function automatic logic [3:0] laneDecode(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] lanes;
      case (size)
         HSIZE_8BITS:  lanes = 4'b0001 << a;
         HSIZE_16BITS: lanes = a[1] ? 4'b1100 : 4'b0011;
         default:      lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             write_q, write_d;
   logic [3:0]       lanes_q, lanes_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic              accept;
   logic              reqErr;
   logic              sizeErr;
   logic              alignErr;
   logic              rangeErr;
   logic [ADDR_W-1:0] upperBits;
   logic [3:0]        memWe;
   logic [31:0]       memRdata;
   logic              unusedBurst;

   // Every beat is decoded on its own, so the burst type carries no information here.
   assign unusedBurst = ^hburst_i;

   assign accept    = hsel_i & hready_i & htrans_i[1] & hreadyout_o;
   assign upperBits = haddr_i >> (IDX_W + 2);
   assign sizeErr   = hsize_i > HSIZE_32BITS;
   assign alignErr  = ((hsize_i == HSIZE_16BITS) && haddr_i[0]) ||
                      ((hsize_i == HSIZE_32BITS) && (haddr_i[1:0] != 2'b00));
   assign rangeErr  = |upperBits;
   assign reqErr    = sizeErr | alignErr | rangeErr;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A new address phase may only be taken where the previous data phase is completing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_ERR2: begin
            state_d = S_IDLE;
            if (accept) begin
               if (reqErr) begin
                  state_d = S_ERR1;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_RELOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hreadyout_o = 1'b1;
      hresp_o     = HRESP_OKAY;
      case (state_q)
         S_WAIT: hreadyout_o = 1'b0;
         S_ERR1: begin
            hreadyout_o = 1'b0;
            hresp_o     = HRESP_ERROR;
         end
         S_ERR2:  hresp_o = HRESP_ERROR;
         default: hreadyout_o = 1'b1;
      endcase
   end

   // pend_q marks an OKAY data phase in flight; errored requests never set it.
   always_comb begin
      pend_d  = pend_q;
      write_d = write_q;
      lanes_d = lanes_q;
      idx_d   = idx_q;
      if (hreadyout_o) begin
         pend_d = accept & ~reqErr;
         if (accept) begin
            write_d = hwrite_i;
            lanes_d = laneDecode(hsize_i, haddr_i[1:0]);
            idx_d   = haddr_i[IDX_W+1:2];
         end
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         lanes_q <= '0;
         idx_q   <= '0;
      end else begin
         pend_q  <= pend_d;
         write_q <= write_d;
         lanes_q <= lanes_d;
         idx_q   <= idx_d;
      end
   end

   // Commit lands on the edge that ends the write data phase, i.e. while ready is high.
   assign memWe    = (pend_q && write_q && (state_q == S_IDLE)) ? lanes_q : 4'b0000;
   assign hrdata_o = (pend_q && !write_q) ? memRdata : 32'h0;

   ahb2_sram_mem #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .we_i     (memWe),
      .idx_i    (idx_q),
      .wdata_i  (hwdata_i),
      .rdata_o  (memRdata)
   );

endmodule
